// File: rtl/sonar_filter_if.sv
// Sample/result bundle between the sonar front end (master) and sonar_filter (slave).
interface sonar_filter_if;
   logic       en;
   logic [7:0] dist_in;
   logic       dist_valid;
   logic [7:0] avg;
   logic       avg_valid;
   logic       near;
   logic       stale;

   modport master (output en, dist_in, dist_valid, input avg, avg_valid, near, stale);
   modport slave  (input en, dist_in, dist_valid, output avg, avg_valid, near, stale);
endinterface

// File: rtl/sonar_filter.sv
// Sonar distance filter: 4-sample moving average, near flag with hysteresis, stale detection.
// Define SONAR_FILTER_MEDIAN_EN to insert a median-of-3 prefilter (avg latency becomes 2).
module sonar_filter #(
   parameter logic [7:0] THRESH_NEAR  = 8'd20,
   parameter logic [7:0] HYST         = 8'd4,
   parameter int         STALE_CYCLES = 1500000
) (
   input logic           clk,
   input logic           reset,
   sonar_filter_if.slave bus
);
   localparam int             CW        = (STALE_CYCLES < 1) ? 1 : $clog2(STALE_CYCLES + 1);
   localparam logic [CW-1:0]  STALE_MAX = CW'(STALE_CYCLES);
   localparam logic [8:0]     EXIT_SUM  = {1'b0, THRESH_NEAR} + {1'b0, HYST};
   localparam logic [7:0]     EXIT_THR  = EXIT_SUM[8] ? 8'hFF : EXIT_SUM[7:0];
   localparam logic [0:0]     ST_FAR    = 1'b0;
   localparam logic [0:0]     ST_NEAR   = 1'b1;

   logic       accept;
   logic [7:0] win_in;
   logic       win_load;

   assign accept = bus.en & bus.dist_valid;

`ifdef SONAR_FILTER_MEDIAN_EN
   function automatic logic [7:0] median3(input logic [7:0] a, input logic [7:0] b,
                                          input logic [7:0] c);
      logic [7:0] lo;
      logic [7:0] hi;
      lo = (a < b) ? a : b;
      hi = (a < b) ? b : a;
      if (c <= lo)      return lo;
      else if (c >= hi) return hi;
      else              return c;
   endfunction

   logic [7:0] hist_q [3];
   logic [7:0] hist_d [3];
   logic       hist_full_q, hist_full_d;
   logic [7:0] med_q, med_d;
   logic       med_valid_q, med_valid_d;

   always_comb begin
      hist_d      = hist_q;
      hist_full_d = hist_full_q;
      med_d       = med_q;
      med_valid_d = accept;
      if (!bus.en) begin
         hist_full_d = 1'b0;
      end else if (accept) begin
         if (!hist_full_q) begin
            for (int i = 0; i < 3; i++) hist_d[i] = bus.dist_in;
            hist_full_d = 1'b1;
         end else begin
            hist_d[2] = hist_q[1];
            hist_d[1] = hist_q[0];
            hist_d[0] = bus.dist_in;
         end
         med_d = median3(hist_d[0], hist_d[1], hist_d[2]);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 3; i++) hist_q[i] <= 8'd0;
         hist_full_q <= 1'b0;
         med_q       <= 8'd0;
         med_valid_q <= 1'b0;
      end else begin
         hist_q      <= hist_d;
         hist_full_q <= hist_full_d;
         med_q       <= med_d;
         med_valid_q <= med_valid_d;
      end
   end

   // The median stage adds one cycle; dropping en discards a median still in flight.
   assign win_in   = med_q;
   assign win_load = med_valid_q & bus.en;
`else
   assign win_in   = bus.dist_in;
   assign win_load = accept;
`endif

   logic [7:0]    win_q [4];
   logic [7:0]    win_d [4];
   logic          win_full_q, win_full_d;
   logic [9:0]    sum_q, sum_d;
   logic [7:0]    avg_q, avg_d;
   logic          avg_valid_q, avg_valid_d;
   logic          avg_valid_o;
   logic [0:0]    near_q, near_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          stale_q, stale_d;

   assign avg_valid_o = avg_valid_q & bus.en;

   always_comb begin
      win_d       = win_q;
      win_full_d  = win_full_q;
      sum_d       = sum_q;
      avg_d       = avg_q;
      avg_valid_d = win_load;
      if (!bus.en) begin
         win_full_d = 1'b0;
      end else if (win_load) begin
         if (!win_full_q) begin
            for (int i = 0; i < 4; i++) win_d[i] = win_in;
            sum_d      = {win_in, 2'b00};
            win_full_d = 1'b1;
         end else begin
            for (int i = 3; i > 0; i--) win_d[i] = win_q[i-1];
            win_d[0] = win_in;
            // sum always holds the evicted entry, so this cannot underflow
            sum_d = sum_q + {2'b00, win_in} - {2'b00, win_q[3]};
         end
         avg_d = sum_d[9:2];
      end
   end

   always_comb begin
      near_d = near_q;
      if (!bus.en) begin
         near_d = ST_FAR;
      end else if (avg_valid_o) begin
         case (near_q)
            ST_FAR:  if (avg_q < THRESH_NEAR) near_d = ST_NEAR;
            ST_NEAR: if (avg_q >= EXIT_THR)   near_d = ST_FAR;
            default: near_d = ST_FAR;
         endcase
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (!bus.en || accept)     cnt_d = '0;
      else if (cnt_q != STALE_MAX) cnt_d = cnt_q + CW'(1);
      stale_d = (cnt_d == STALE_MAX);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 4; i++) win_q[i] <= 8'd0;
         win_full_q  <= 1'b0;
         sum_q       <= 10'd0;
         avg_q       <= 8'd0;
         avg_valid_q <= 1'b0;
         near_q      <= ST_FAR;
         cnt_q       <= '0;
         stale_q     <= 1'b0;
      end else begin
         win_q       <= win_d;
         win_full_q  <= win_full_d;
         sum_q       <= sum_d;
         avg_q       <= avg_d;
         avg_valid_q <= avg_valid_d;
         near_q      <= near_d;
         cnt_q       <= cnt_d;
         stale_q     <= stale_d;
      end
   end

   assign bus.avg       = avg_q;
   assign bus.avg_valid = avg_valid_o;
   assign bus.near      = (near_q == ST_NEAR);
   assign bus.stale     = stale_q;
endmodule

// File: tb/tb_sonar_filter.sv
// Randomized self-checking bench for sonar_filter against a queue-based reference model.
module tb_sonar_filter;
   localparam int         STALE = 40;
   localparam logic [7:0] TH    = 8'd20;
   localparam logic [7:0] HY    = 8'd4;
`ifdef SONAR_FILTER_MEDIAN_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   sonar_filter_if bus ();

   sonar_filter #(.THRESH_NEAR(TH), .HYST(HY), .STALE_CYCLES(STALE)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;

   // reference model state
   int         m_win[$];
   int         m_hist[$];
   int         m_med;
   bit         m_medv;
   int         m_cnt;
   logic [7:0] exp_avg;
   logic       exp_valid;
   logic       exp_near;
   logic       exp_stale;

   function automatic int med3(input int a, input int b, input int c);
      int mx, mn;
      mx = (a > b) ? a : b; mx = (mx > c) ? mx : c;
      mn = (a < b) ? a : b; mn = (mn < c) ? mn : c;
      return a + b + c - mx - mn;
   endfunction

   task automatic model_reset();
      m_win.delete(); m_hist.delete();
      m_med = 0; m_medv = 0; m_cnt = 0;
      exp_avg = 8'd0; exp_valid = 1'b0; exp_near = 1'b0; exp_stale = 1'b0;
   endtask

   // Drive one cycle of inputs, clock the DUT, advance the model to the post-edge state.
   task automatic step(input bit e, input bit v, input logic [7:0] d);
      bit acc, wv;
      int wi, s, ex;
      bus.en = e; bus.dist_valid = v; bus.dist_in = d;
      @(posedge clk);
      acc = e && v;
      if (!e || acc) m_cnt = 0;
      else if (m_cnt < STALE) m_cnt++;
      exp_stale = (m_cnt == STALE);
      ex = int'(TH) + int'(HY);
      if (ex > 255) ex = 255;
      if (!e) exp_near = 1'b0;
      else if (exp_valid) begin
         if (!exp_near && int'(exp_avg) < int'(TH)) exp_near = 1'b1;
         else if (exp_near && int'(exp_avg) >= ex) exp_near = 1'b0;
      end
`ifdef SONAR_FILTER_MEDIAN_EN
      wv = m_medv && e;
      wi = m_med;
      m_medv = acc;
      if (!e) m_hist.delete();
      else if (acc) begin
         if (m_hist.size() == 0) repeat (3) m_hist.push_front(int'(d));
         else begin m_hist.push_front(int'(d)); void'(m_hist.pop_back()); end
         m_med = med3(m_hist[0], m_hist[1], m_hist[2]);
      end
`else
      wv = acc;
      wi = int'(d);
`endif
      if (!e) m_win.delete();
      else if (wv) begin
         if (m_win.size() == 0) repeat (4) m_win.push_front(wi);
         else begin m_win.push_front(wi); void'(m_win.pop_back()); end
         s = 0;
         foreach (m_win[i]) s += m_win[i];
         exp_avg = 8'(s / 4);
      end
      exp_valid = wv;
      #1;
   endtask

   // Send one sample, wait (bounded) for its avg pulse, then one idle cycle for near to settle.
   task automatic send(input logic [7:0] d, output logic [7:0] got, output logic got_near,
                       output bit seen);
      seen = 1'b0; got = 8'd0;
      step(1'b1, 1'b1, d);
      for (int k = 0; k < 4 && !seen; k++) begin
         if (bus.avg_valid === 1'b1) begin seen = 1'b1; got = bus.avg; end
         else step(1'b1, 1'b0, 8'd0);
      end
      step(1'b1, 1'b0, 8'd0);
      got_near = bus.near;
   endtask

   task automatic test_reset();
      reset = 1'b1; bus.en = 1'b1; bus.dist_valid = 1'b1; bus.dist_in = 8'($urandom);
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      total++; if (bus.avg !== 8'd0)       begin bad++; $display("FAIL reset_avg got=%0d want=0", bus.avg); end
      total++; if (bus.avg_valid !== 1'b0) begin bad++; $display("FAIL reset_avg_valid got=%b want=0", bus.avg_valid); end
      total++; if (bus.near !== 1'b0)      begin bad++; $display("FAIL reset_near got=%b want=0", bus.near); end
      total++; if (bus.stale !== 1'b0)     begin bad++; $display("FAIL reset_stale got=%b want=0", bus.stale); end
      reset = 1'b0; bus.dist_valid = 1'b0;
      $display("reset: avg=%0d avg_valid=%b near=%b stale=%b", bus.avg, bus.avg_valid, bus.near, bus.stale);
   endtask

   task automatic test_single();
      test_reset();
      step(1'b1, 1'b1, 8'd40);
      for (int k = 1; k <= LAT; k++) begin
         if (k > 1) step(1'b1, 1'b0, 8'd0);
         total++;
         if (bus.avg_valid !== (k == LAT))
            begin bad++; $display("FAIL single_latency cyc=%0d got=%b want=%b", k, bus.avg_valid, (k == LAT)); end
      end
      total++; if (bus.avg !== 8'd40) begin bad++; $display("FAIL single_avg got=%0d want=40", bus.avg); end
      total++; if (bus.near !== 1'b0) begin bad++; $display("FAIL single_near got=%b want=0", bus.near); end
      step(1'b1, 1'b0, 8'd0);
      total++; if (bus.avg_valid !== 1'b0) begin bad++; $display("FAIL single_pulse_width got=%b want=0", bus.avg_valid); end
      $display("single: sample=40 avg=%0d near=%b", bus.avg, bus.near);
   endtask

   task automatic test_sequence();
      logic [7:0] smp [8] = '{8'd40, 8'd40, 8'd40, 8'd40, 8'd0, 8'd0, 8'd0, 8'd0};
      logic [7:0] want_avg [8] = '{8'd40, 8'd40, 8'd40, 8'd40, 8'd30, 8'd20, 8'd10, 8'd0};
      logic want_near [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      logic [7:0] got;
      logic gn;
      bit seen;
      test_reset();
      for (int i = 0; i < 8; i++) begin
         send(smp[i], got, gn, seen);
         total++; if (!seen) begin bad++; $display("FAIL seq_timeout idx=%0d no avg_valid within bound", i); end
         total++; if (got !== exp_avg) begin bad++; $display("FAIL seq_avg idx=%0d got=%0d want=%0d", i, got, exp_avg); end
         total++; if (gn !== exp_near) begin bad++; $display("FAIL seq_near idx=%0d got=%b want=%b", i, gn, exp_near); end
`ifndef SONAR_FILTER_MEDIAN_EN
         total++; if (got !== want_avg[i]) begin bad++; $display("FAIL seq_avg_const idx=%0d got=%0d want=%0d", i, got, want_avg[i]); end
         total++; if (gn !== want_near[i]) begin bad++; $display("FAIL seq_near_const idx=%0d got=%b want=%b", i, gn, want_near[i]); end
`endif
         $display("sequence: sample=%0d avg=%0d near=%b", smp[i], got, gn);
      end
   endtask

   task automatic test_hysteresis();
      logic [7:0] smp [2] = '{8'd92, 8'd4};
      logic [7:0] want_avg [2] = '{8'd23, 8'd24};
      logic want_near [2] = '{1'b1, 1'b0};
      logic [7:0] got;
      logic gn;
      bit seen;
      for (int i = 0; i < 2; i++) begin
         send(smp[i], got, gn, seen);
         total++; if (!seen) begin bad++; $display("FAIL hyst_timeout idx=%0d no avg_valid within bound", i); end
         total++; if (got !== exp_avg) begin bad++; $display("FAIL hyst_avg idx=%0d got=%0d want=%0d", i, got, exp_avg); end
         total++; if (gn !== exp_near) begin bad++; $display("FAIL hyst_near idx=%0d got=%b want=%b", i, gn, exp_near); end
`ifndef SONAR_FILTER_MEDIAN_EN
         total++; if (got !== want_avg[i]) begin bad++; $display("FAIL hyst_avg_const idx=%0d got=%0d want=%0d", i, got, want_avg[i]); end
         total++; if (gn !== want_near[i]) begin bad++; $display("FAIL hyst_near_const idx=%0d got=%b want=%b", i, gn, want_near[i]); end
`endif
         $display("hysteresis: sample=%0d avg=%0d near=%b", smp[i], got, gn);
      end
   endtask

   task automatic test_stale();
      test_reset();
      for (int i = 1; i <= STALE + 5; i++) begin
         step(1'b1, 1'b0, 8'd0);
         total++;
         if (bus.stale !== (i >= STALE))
            begin bad++; $display("FAIL stale_rise idle=%0d got=%b want=%b", i, bus.stale, (i >= STALE)); end
      end
      step(1'b1, 1'b1, 8'd7);
      total++; if (bus.stale !== 1'b0) begin bad++; $display("FAIL stale_clear got=%b want=0", bus.stale); end
      $display("stale: rose after %0d idle cycles, cleared by sample", STALE);
      for (int i = 1; i < STALE; i++) begin
         step(1'b1, 1'b0, 8'd0);
         total++; if (bus.stale !== 1'b0) begin bad++; $display("FAIL stale_early idle=%0d got=%b want=0", i, bus.stale); end
      end
      step(1'b1, 1'b1, 8'd9);
      for (int i = 0; i < 4; i++) begin
         total++; if (bus.stale !== 1'b0) begin bad++; $display("FAIL stale_terminal cyc=%0d got=%b want=0", i, bus.stale); end
         step(1'b1, 1'b0, 8'd0);
      end
      $display("stale: sample on terminal cycle, stale=%b", bus.stale);
   endtask

   task automatic test_en_drop();
      logic [7:0] got;
      logic gn;
      bit seen;
      test_reset();
      repeat (4) send(8'd40, got, gn, seen);
      for (int i = 0; i < 6; i++) begin
         step(1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
         total++; if (bus.avg !== 8'd40)      begin bad++; $display("FAIL endrop_avg_hold cyc=%0d got=%0d want=40", i, bus.avg); end
         total++; if (bus.avg_valid !== 1'b0) begin bad++; $display("FAIL endrop_valid cyc=%0d got=%b want=0", i, bus.avg_valid); end
         total++; if (bus.near !== 1'b0)      begin bad++; $display("FAIL endrop_near cyc=%0d got=%b want=0", i, bus.near); end
         total++; if (bus.stale !== 1'b0)     begin bad++; $display("FAIL endrop_stale cyc=%0d got=%b want=0", i, bus.stale); end
      end
      send(8'd100, got, gn, seen);
      total++; if (!seen)          begin bad++; $display("FAIL endrop_timeout no avg_valid within bound"); end
      total++; if (got !== 8'd100) begin bad++; $display("FAIL endrop_reprime got=%0d want=100", got); end
      total++; if (gn !== 1'b0)    begin bad++; $display("FAIL endrop_near_after got=%b want=0", gn); end
      $display("en_drop: held avg=40, reprimed avg=%0d near=%b", got, gn);
   endtask

   task automatic test_back_to_back();
      int pulses;
      test_reset();
      pulses = 0;
      for (int i = 0; i < 8 + LAT; i++) begin
         if (i < 8) step(1'b1, 1'b1, 8'($urandom_range(0, 80)));
         else       step(1'b1, 1'b0, 8'd0);
         if (bus.avg_valid === 1'b1) pulses++;
         total++; if (bus.avg !== exp_avg) begin bad++; $display("FAIL b2b_avg cyc=%0d got=%0d want=%0d", i, bus.avg, exp_avg); end
      end
      total++; if (pulses !== 8) begin bad++; $display("FAIL b2b_pulses got=%0d want=8", pulses); end
      $display("back_to_back: 8 consecutive samples, %0d avg pulses", pulses);
      for (int i = 0; i < 300; i++) begin
         step($urandom_range(0, 19) != 0, $urandom_range(0, 9) < 6, 8'($urandom_range(0, 60)));
         total++; if (bus.avg_valid !== exp_valid) begin bad++; $display("FAIL rand_valid cyc=%0d got=%b want=%b", i, bus.avg_valid, exp_valid); end
         total++; if (bus.avg !== exp_avg)         begin bad++; $display("FAIL rand_avg cyc=%0d got=%0d want=%0d", i, bus.avg, exp_avg); end
         total++; if (bus.near !== exp_near)       begin bad++; $display("FAIL rand_near cyc=%0d got=%b want=%b", i, bus.near, exp_near); end
         total++; if (bus.stale !== exp_stale)     begin bad++; $display("FAIL rand_stale cyc=%0d got=%b want=%b", i, bus.stale, exp_stale); end
      end
      $display("random: 300 cycles compared, last avg=%0d near=%b", bus.avg, bus.near);
   endtask

`ifdef SONAR_FILTER_MEDIAN_EN
   task automatic test_median();
      logic [7:0] smp [3] = '{8'd40, 8'd200, 8'd40};
      test_reset();
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b1, smp[i]);
         total++; if (bus.avg_valid !== 1'b0) begin bad++; $display("FAIL median_early idx=%0d got=%b want=0", i, bus.avg_valid); end
         step(1'b1, 1'b0, 8'd0);
         total++; if (bus.avg_valid !== 1'b1) begin bad++; $display("FAIL median_valid idx=%0d got=%b want=1", i, bus.avg_valid); end
         total++; if (bus.avg !== 8'd40)      begin bad++; $display("FAIL median_avg idx=%0d got=%0d want=40", i, bus.avg); end
         step(1'b1, 1'b0, 8'd0);
         $display("median: sample=%0d avg=%0d", smp[i], bus.avg);
      end
   endtask
`endif

   initial begin
      #2_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; bus.en = 1'b0; bus.dist_valid = 1'b0; bus.dist_in = 8'd0;
      model_reset();
      test_reset();
      test_single();
      test_sequence();
      test_hysteresis();
      test_stale();
      test_en_drop();
      test_back_to_back();
`ifdef SONAR_FILTER_MEDIAN_EN
      test_median();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/sonar_filter.md
SONAR_FILTER -- requirements
Module: sonar_filter

Interface
REQ-001 Parameter THRESH_NEAR, default 8'd20, near-entry threshold in dist units (0.54 in each).
REQ-002 Parameter HYST, default 8'd4, hysteresis added to THRESH_NEAR for near exit.
REQ-003 Parameter STALE_CYCLES, default 1500000, clk cycles without a sample before stale is flagged (30 ms at 50 MHz).
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 en  input  1  filter enable; low flushes filter state.
REQ-007 dist_in  input  8  raw distance sample from the sonar front end.
REQ-008 dist_valid  input  1  one-cycle strobe qualifying dist_in.
REQ-009 avg  output  8  filtered distance.
REQ-010 avg_valid  output  1  one-cycle strobe, avg updated.
REQ-011 near  output  1  object-near flag with hysteresis.
REQ-012 stale  output  1  no sample received for STALE_CYCLES cycles.

Function
REQ-013 A sample is accepted only when dist_valid=1 and en=1; dist_valid with en=0 is ignored.
REQ-014 The block keeps a 4-entry sample window (8 bits each) and a 10-bit running sum; sum never overflows (max 1020).
REQ-015 First accepted sample after reset or after en low (window empty) primes all 4 entries with that sample and sum to 4*sample.
REQ-016 Each later accepted sample shifts the window; sum <= sum + new - oldest, oldest being the evicted entry.
REQ-017 avg = sum[9:2] (truncating divide by 4), registered; avg and avg_valid=1 appear the cycle after acceptance (latency 1); avg_valid is low in all other cycles.
REQ-018 Back-to-back dist_valid on consecutive cycles are each accepted; each yields its own avg_valid pulse.
REQ-019 near state machine, two states: FAR (near=0) and NEAR (near=1); evaluated only in the cycle avg_valid is asserted, using the new avg.
REQ-020 FAR->NEAR when new avg < THRESH_NEAR; NEAR->FAR when new avg >= THRESH_NEAR+HYST, computed 9-bit and saturated to 255.
REQ-021 Stale counter increments each cycle while en=1 and no sample accepted, saturating at STALE_CYCLES; stale=1 while counter == STALE_CYCLES.
REQ-022 An accepted sample clears counter and stale on the next clock; if acceptance coincides with counter reaching STALE_CYCLES, acceptance wins and stale stays 0.
REQ-023 en=0: window marked empty, counter cleared, stale=0, near returns to FAR, avg_valid=0; avg holds its last value.

Reset
REQ-024 reset=1 forces avg=0, avg_valid=0, near=0 (FAR), stale=0, counter=0, window empty, sum=0; reset dominates en and dist_valid, including mid-operation.

Configuration
REQ-025 Macro SONAR_FILTER_MEDIAN_EN defined: a median-of-3 prefilter over the last three accepted raw samples feeds the window; prefilter history primes with the first sample like REQ-015; avg latency becomes 2 cycles; en=0 and reset also empty the prefilter history.
REQ-026 SONAR_FILTER_MEDIAN_EN undefined: no prefilter; raw samples feed the window directly, latency 1.

Verification
REQ-027 Reset, en=1, single sample 40 -> next cycle avg=40, avg_valid=1 for one cycle, near=0.
REQ-028 Samples 40,40,40,40 then 0 -> avg 40,40,40,40,30; then 0,0,0 -> 20,10,0; near sets at avg=10 (<20), not at 20.
REQ-029 In NEAR, samples raising avg to 23 -> near stays 1; avg 24 -> near=0.
REQ-030 No samples for 1500000 cycles -> stale=1 exactly at count, remains 1; one sample -> stale=0 next cycle; sample on the terminal cycle -> stale never rises.
REQ-031 en dropped mid-stream after 40,40,40,40, then en=1 and sample 100 -> avg=100 (re-primed), near=0, avg unchanged at 40 during en=0.
REQ-032 With SONAR_FILTER_MEDIAN_EN: primed 40, then spike 200, then 40 -> median outputs 40,40,40 and every avg=40, each 2 cycles after its sample.
